shift_rx_ctrl: RTL and testbench
================================

# shift_rx_ctrl

Serial-frame receive controller that sits directly upstream of `shift_reg` and drives its `D` and `mode_i` inputs. It oversamples an asynchronous UART-style line: 1 start bit (0), 8 data bits LSB-first, 1 stop bit (1). Each data bit goes into `shift_reg` with a one-cycle RIGHT-shift command, so `P` holds the received byte when the frame completes. It also reports frame completion and framing errors to the consuming logic.

## Interface

- `CLKS_PER_BIT`, default 16: clock cycles per serial bit. Legal values are 4 to 65535. The half-bit delay is `CLKS_PER_BIT/2`, rounded down.
- `clk`  input  1  system clock; all state changes on the rising edge.
- `nrst`  input  1  asynchronous, active-low reset.
- `en_i`  input  1  receive enable. When low, the block is forced to IDLE.
- `rx_i`  input  1  asynchronous serial line, idle high.
- `D_o`  output  1  serial bit to `shift_reg.D`.
- `mode_o`  output  2  command to `shift_reg.mode_i`. Only 2'b00 (HOLD) and 2'b11 (RIGHT) are ever driven.
- `busy_o`  output  1  high in every state except IDLE.
- `frame_done_o`  output  1  one-cycle pulse: the stop bit was valid and `shift_reg.P` holds the byte.
- `framing_err_o`  output  1  one-cycle pulse: the stop bit sampled 0.

## Operation

- **Input path:** `rx_i` passes through a 2-FF synchronizer giving `rx_s`. One more flop gives `rx_q`, used for falling-edge detection. All decisions use `rx_s`.
- **Counters:**
  - Bit-period counter, `$clog2(CLKS_PER_BIT)` bits wide. It reloads to 0 on every state entry and every bit boundary.
  - Bit index counter, 3 bits, counts 0 to 7.
- **State machine: IDLE, START, DATA, STOP, WAIT_HIGH.**
  - **IDLE:** if `en_i` is high and `rx_q`=1 and `rx_s`=0 (falling edge), go to START.
  - **START:** count `CLKS_PER_BIT/2` cycles, then sample `rx_s`.
    - Sample is 0: go to DATA with bit index 0.
    - Sample is 1: treat as a glitch and return to IDLE. No outputs pulse.
  - **DATA:** at the last cycle of each `CLKS_PER_BIT` window, sample `rx_s`.
    - On the next cycle, drive `D_o`=sample and `mode_o`=2'b11 for exactly one cycle, then return `mode_o` to 2'b00.
    - After the sample for bit index 7, go to STOP.
  - **STOP:** after `CLKS_PER_BIT` cycles, sample `rx_s`.
    - Sample is 1: pulse `frame_done_o` and go to IDLE.
    - Sample is 0: pulse `framing_err_o` and go to WAIT_HIGH.
  - **WAIT_HIGH:** stay until `rx_s`=1, then go to IDLE. This blocks false starts on a stuck-low line.
- **Bit order:** `shift_reg` RIGHT mode enters `D` at the MSB. After 8 shifts, the first (LSB) bit lands in `P[0]`, so `P` equals the transmitted byte.
- **No clear command:** the block never issues a LOAD. Eight shifts fully overwrite `P`.
- **`en_i` deasserted in any non-IDLE state:** return to IDLE on the next edge. `mode_o` goes to 00, and no done or error pulse is produced. Bits already shifted stay in `shift_reg`.
- **Reset, asserted at any time:** immediately forces IDLE. Counters go to 0, and `D_o`, `mode_o`, `busy_o`, `frame_done_o`, `framing_err_o` all go to 0.
- **Simultaneous events:**
  - A shift pulse and a state transition can occur in the same cycle. The DATA→STOP shift for bit 7 is still issued.
  - `frame_done_o` and `framing_err_o` are never high together.

## Timing

- All outputs are registered. Reset values are all 0, and `mode_o`=2'b00.
- Start-edge latency: a falling edge on `rx_i` before edge k is seen as `rx_s`=0 at edge k+2. The state is START after edge k+2.
- Sample points, measured from the detected edge:
  - Data bit n (n = 0 to 7) is sampled at `CLKS_PER_BIT/2 + (n+1)*CLKS_PER_BIT` cycles.
  - Its shift pulse appears 1 cycle later.
  - The stop bit is sampled at `CLKS_PER_BIT/2 + 9*CLKS_PER_BIT` cycles. The done or error pulse appears 1 cycle later.
- `mode_o`=2'b11 is high for exactly 1 cycle per data bit, 8 per frame, with at least `CLKS_PER_BIT-1` HOLD cycles between pulses.
- `P` is stable from the `frame_done_o` cycle until the next frame's first shift, at least `CLKS_PER_BIT` cycles later.
- Back-to-back frames: a new start edge can be accepted in the cycle after `frame_done_o`.

## Test plan

All scenarios use `CLKS_PER_BIT`=16, with `shift_reg` instantiated downstream.

- **Power-on reset:** `nrst`=0 with `rx_i` toggling → all outputs 0, `mode_o`=00. After release with `rx_i`=1, the block stays in IDLE and `busy_o`=0.
- **Frame 8'hA5** (line sequence 0,1,0,1,0,0,1,0,1,1) → eight `mode_o`=11 pulses with `D_o` = 1,0,1,0,0,1,0,1. Then one `frame_done_o` pulse 153 cycles after the detected edge, with `P`=8'hA5.
- **Glitch start:** `rx_i` low for 4 cycles, then high → `busy_o` high for 8 cycles, no shift pulses, no done or error, return to IDLE.
- **Framing error:** frame 8'h3C with stop bit 0, line held low for 40 more cycles → one `framing_err_o` pulse, no `frame_done_o`. `busy_o` stays high until `rx_s`=1, and no new frame starts while the line is low.
- **Back-to-back frames:** 8'hFF then 8'h00 with no idle gap → two `frame_done_o` pulses. `P`=8'hFF at the first and `P`=8'h00 at the second.
- **Abort:** `nrst` pulsed low after bit 3 of frame 8'h81, then a clean 8'h81 sent → only 4 shift pulses before reset, outputs 0 during reset, and the second frame yields `frame_done_o` with `P`=8'h81. Repeat using `en_i`=0 instead of reset, expecting the same result.

Source files
------------

// File: rtl/shift_rx_ctrl.sv
// shift_rx_ctrl: oversampling 8N1 serial receiver that drives a downstream shift_reg
// with one RIGHT-shift command per data bit (LSB first) and reports done/framing error.
module shift_rx_ctrl #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       en_i,
    input  logic       rx_i,
    output logic       D_o,
    output logic [1:0] mode_o,
    output logic       busy_o,
    output logic       frame_done_o,
    output logic       framing_err_o
);

    localparam int unsigned      CNT_W      = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [1:0]       MODE_HOLD  = 2'b00;
    localparam logic [1:0]       MODE_RIGHT = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [2:0]       idx, idx_d;
    logic             rx_meta, rx_s, rx_q;
    logic             shift_q, shift_d;
    logic             bit_q, bit_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    // NOTE: the line idles high, so the synchronizer resets to 1 and cannot fake a start edge.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_q    <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rx_s    <= rx_meta;
            rx_q    <= rx_s;
        end
    end

    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    always_comb begin
        state_d = state;
        cnt_d   = cnt + 1'b1;
        idx_d   = idx;
        shift_d = 1'b0;
        bit_d   = bit_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        unique case (state)
            IDLE: begin
                cnt_d = '0;
                if (en_i && rx_q && !rx_s) state_d = START;
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_d   = '0;
                    idx_d   = 3'd0;
                    state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == FULL_LAST) begin
                    cnt_d   = '0;
                    shift_d = 1'b1;
                    bit_d   = rx_s;
                    idx_d   = idx + 3'd1;
                    if (idx == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (cnt == FULL_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                cnt_d = '0;
                if (rx_s) state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        // Disable overrides everything: drop the frame silently, keep shift_reg contents.
        if (!en_i) begin
            state_d = IDLE;
            cnt_d   = '0;
            idx_d   = 3'd0;
            shift_d = 1'b0;
            done_d  = 1'b0;
            err_d   = 1'b0;
        end
    end

    // Sample decisions are staged one flop, so each output pulse lags its sample by a cycle.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state         <= IDLE;
            cnt           <= '0;
            idx           <= 3'd0;
            shift_q       <= 1'b0;
            bit_q         <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            D_o           <= 1'b0;
            mode_o        <= MODE_HOLD;
            busy_o        <= 1'b0;
            frame_done_o  <= 1'b0;
            framing_err_o <= 1'b0;
        end else begin
            state         <= state_d;
            cnt           <= cnt_d;
            idx           <= idx_d;
            shift_q       <= shift_d;
            bit_q         <= bit_d;
            done_q        <= done_d;
            err_q         <= err_d;
            D_o           <= shift_q && en_i && bit_q;
            mode_o        <= (shift_q && en_i) ? MODE_RIGHT : MODE_HOLD;
            busy_o        <= (state_d != IDLE);
            frame_done_o  <= done_q && en_i;
            framing_err_o <= err_q && en_i;
        end
    end

endmodule

// File: tb/tb_shift_rx_ctrl.sv
// Directed bench for shift_rx_ctrl at 16 clocks per bit, with a behavioural
// stand-in for the downstream shift_reg (RIGHT mode enters D at the MSB).
module tb_shift_rx_ctrl;

    localparam int CPB = 16;

    logic       clk;
    logic       nrst;
    logic       en_i;
    logic       rx_i;
    logic       D_o;
    logic [1:0] mode_o;
    logic       busy_o;
    logic       frame_done_o;
    logic       framing_err_o;

    int total = 0;
    int bad   = 0;

    shift_rx_ctrl #(.CLKS_PER_BIT(CPB)) dut (
        .clk          (clk),
        .nrst         (nrst),
        .en_i         (en_i),
        .rx_i         (rx_i),
        .D_o          (D_o),
        .mode_o       (mode_o),
        .busy_o       (busy_o),
        .frame_done_o (frame_done_o),
        .framing_err_o(framing_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         cyc = 0;
    logic [7:0] p_model = 8'h00;
    logic       busy_prev = 1'b0;
    int         n_busy = 0;
    int         start_q[$];
    int         shift_cyc_q[$];
    logic       shift_bits_q[$];
    int         done_q[$];
    logic [7:0] p_done_q[$];
    int         err_q[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mode_o == 2'b11) p_model <= {D_o, p_model[7:1]};
    end

    always @(negedge clk) begin
        busy_prev <= busy_o;
        if (busy_o) n_busy <= n_busy + 1;
        if (busy_o && !busy_prev) start_q.push_back(cyc);
        if (mode_o == 2'b11) begin
            shift_cyc_q.push_back(cyc);
            shift_bits_q.push_back(D_o);
        end
        if (frame_done_o) begin
            done_q.push_back(cyc);
            p_done_q.push_back(p_model);
        end
        if (framing_err_o) err_q.push_back(cyc);
    end

    initial begin
        #200us;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {26'd0, D_o, mode_o, busy_o, frame_done_o, framing_err_o};
    endfunction

    // frame = {stop, data[7:0], start}, sent LSB first, one bit per CPB cycles.
    task automatic send_bits(input logic [9:0] frame, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            rx_i = frame[i];
            repeat (CPB) @(negedge clk);
        end
        rx_i = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        send_bits({stop, b, 1'b0}, 10);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Per-frame timing and content: shift bits, first shift at 25, spacing 16, done at 153.
    task automatic check_frame(input string tag, input logic [7:0] b, input int sb, input int db, input int stb);
        logic ok;
        ok = (shift_cyc_q.size() >= sb + 8) && (done_q.size() > db) && (start_q.size() > stb);
        check({tag, "_events"}, 32'(ok), 32'd1);
        if (ok) begin
            for (int i = 0; i < 8; i++)
                check($sformatf("%s_d%0d", tag, i), 32'(shift_bits_q[sb + i]), 32'(b[i]));
            check({tag, "_first_shift"}, 32'(shift_cyc_q[sb] - start_q[stb]), 32'd25);
            check({tag, "_shift_gap"}, 32'(shift_cyc_q[sb + 1] - shift_cyc_q[sb]), 32'd16);
            check({tag, "_done_lat"}, 32'(done_q[db] - start_q[stb]), 32'd153);
            check({tag, "_p"}, 32'(p_done_q[db]), 32'(b));
        end
    endtask

    initial begin
        int sb, db, eb, stb, bb;

        // Power-on reset with the line toggling.
        nrst = 1'b0;
        en_i = 1'b1;
        rx_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            rx_i = i[0];
            check($sformatf("reset_outs%0d", i), outs(), 32'd0);
        end
        rx_i = 1'b1;
        @(negedge clk);
        nrst = 1'b1;
        idle(20);
        check("post_reset_outs", outs(), 32'd0);
        check("post_reset_starts", 32'(start_q.size()), 32'd0);

        // Frame 8'hA5.
        sb = shift_cyc_q.size(); db = done_q.size(); eb = err_q.size(); stb = start_q.size();
        send_byte(8'hA5, 1'b1);
        idle(20);
        check("a5_shifts", 32'(shift_cyc_q.size() - sb), 32'd8);
        check("a5_dones", 32'(done_q.size() - db), 32'd1);
        check("a5_errs", 32'(err_q.size() - eb), 32'd0);
        check_frame("a5", 8'hA5, sb, db, stb);
        check("a5_idle", outs(), 32'd0);

        // Glitch start: line low for 4 cycles.
        sb = shift_cyc_q.size(); db = done_q.size(); eb = err_q.size(); stb = start_q.size();
        bb = n_busy;
        rx_i = 1'b0;
        idle(4);
        rx_i = 1'b1;
        idle(20);
        check("glitch_busy_cycles", 32'(n_busy - bb), 32'd8);
        check("glitch_starts", 32'(start_q.size() - stb), 32'd1);
        check("glitch_shifts", 32'(shift_cyc_q.size() - sb), 32'd0);
        check("glitch_dones", 32'(done_q.size() - db), 32'd0);
        check("glitch_errs", 32'(err_q.size() - eb), 32'd0);
        check("glitch_idle", outs(), 32'd0);

        // Framing error: 8'h3C with a low stop bit, line held low 40 more cycles.
        sb = shift_cyc_q.size(); db = done_q.size(); eb = err_q.size(); stb = start_q.size();
        send_bits({1'b0, 8'h3C, 1'b0}, 10);
        rx_i = 1'b0;
        idle(40);
        check("ferr_busy_low_line", 32'(busy_o), 32'd1);
        rx_i = 1'b1;
        idle(6);
        check("ferr_busy_released", 32'(busy_o), 32'd0);
        check("ferr_errs", 32'(err_q.size() - eb), 32'd1);
        check("ferr_dones", 32'(done_q.size() - db), 32'd0);
        check("ferr_starts", 32'(start_q.size() - stb), 32'd1);
        check("ferr_shifts", 32'(shift_cyc_q.size() - sb), 32'd8);
        if (err_q.size() > eb && start_q.size() > stb)
            check("ferr_lat", 32'(err_q[eb] - start_q[stb]), 32'd153);
        idle(20);

        // Back-to-back 8'hFF then 8'h00 with no idle gap.
        sb = shift_cyc_q.size(); db = done_q.size(); eb = err_q.size(); stb = start_q.size();
        send_byte(8'hFF, 1'b1);
        send_byte(8'h00, 1'b1);
        idle(20);
        check("b2b_dones", 32'(done_q.size() - db), 32'd2);
        check("b2b_shifts", 32'(shift_cyc_q.size() - sb), 32'd16);
        check("b2b_errs", 32'(err_q.size() - eb), 32'd0);
        check_frame("b2b_ff", 8'hFF, sb, db, stb);
        check_frame("b2b_00", 8'h00, sb + 8, db + 1, stb + 1);
        if (done_q.size() >= db + 2)
            check("b2b_done_gap", 32'(done_q[db + 1] - done_q[db]), 32'd160);

        // Abort by reset after bit 3 of 8'h81, then a clean 8'h81.
        sb = shift_cyc_q.size(); db = done_q.size(); eb = err_q.size();
        send_bits({1'b1, 8'h81, 1'b0}, 5);
        nrst = 1'b0;
        #1;
        check("abort_rst_outs_a", outs(), 32'd0);
        idle(3);
        check("abort_rst_outs_b", outs(), 32'd0);
        nrst = 1'b1;
        idle(10);
        check("abort_rst_shifts", 32'(shift_cyc_q.size() - sb), 32'd4);
        check("abort_rst_nodone", 32'(done_q.size() - db), 32'd0);
        sb = shift_cyc_q.size(); stb = start_q.size();
        send_byte(8'h81, 1'b1);
        idle(20);
        check("abort_rst_dones", 32'(done_q.size() - db), 32'd1);
        check("abort_rst_errs", 32'(err_q.size() - eb), 32'd0);
        check_frame("abort_rst_81", 8'h81, sb, db, stb);

        // Abort by en_i low after bit 3 of 8'h81, then a clean 8'h81.
        sb = shift_cyc_q.size(); db = done_q.size(); eb = err_q.size();
        send_bits({1'b1, 8'h81, 1'b0}, 5);
        en_i = 1'b0;
        idle(2);
        check("abort_en_outs", outs(), 32'd0);
        idle(3);
        en_i = 1'b1;
        idle(10);
        check("abort_en_shifts", 32'(shift_cyc_q.size() - sb), 32'd4);
        check("abort_en_nodone", 32'(done_q.size() - db), 32'd0);
        sb = shift_cyc_q.size(); stb = start_q.size();
        send_byte(8'h81, 1'b1);
        idle(20);
        check("abort_en_dones", 32'(done_q.size() - db), 32'd1);
        check("abort_en_errs", 32'(err_q.size() - eb), 32'd0);
        check_frame("abort_en_81", 8'h81, sb, db, stb);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
